cnn_layer_scheduler: RTL
========================

Name: cnn_layer_scheduler

Overview:
- Sequences multi-layer CNN inference on the DMA/CNN core by issuing one ap_start per layer and waiting for ap_done.
- Generates per-layer read/write addresses, ping-ponging intermediate feature maps between two DDR buffers.
- Sits between the AXI-Lite register slave and the DMA core, replacing direct software ap_start control.
- Provides a watchdog and a graceful abort.

Parameters:
- LAYER_W, 4, width of layer count/index (max 2^LAYER_W-1 layers)
- ADDR_W, 32, DDR byte address width
- TMO_W, 32, watchdog counter width

Ports:
- ap_clk  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- cfg_start  in  1  one-cycle pulse; starts a sequence (ignored unless IDLE/DONE/ERR)
- cfg_abort  in  1  one-cycle pulse; stop after the current layer completes
- cfg_num_layers  in  LAYER_W  layers to run; 0 = empty sequence
- cfg_in_addr  in  ADDR_W  input frame address
- cfg_out_addr  in  ADDR_W  final output address
- cfg_buf0_addr  in  ADDR_W  ping buffer
- cfg_buf1_addr  in  ADDR_W  pong buffer
- cfg_width  in  12  frame width
- cfg_height  in  12  frame height
- cfg_timeout  in  TMO_W  per-layer cycle limit; 0 disables
- ap_start  out  1  to core; held until ap_ready
- ap_ready  in  1  core accepted start
- ap_done  in  1  core layer-complete pulse
- ap_idle  in  1  core idle
- read_address  out  ADDR_W  IFM address for current layer
- write_address  out  ADDR_W  OFM address for current layer
- input_width  out  12  registered cfg_width
- input_height  out  12  registered cfg_height
- input_framesize  out  24  input_width*input_height
- layer_idx  out  LAYER_W  current layer index
- busy  out  1  sequence in progress
- seq_done  out  1  one-cycle pulse at sequence end
- aborted  out  1  sticky; last sequence ended by abort
- timeout_err  out  1  sticky; watchdog fired

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset applies immediately at any point, including mid-layer; the core is not signalled.
- Config capture on accepted cfg_start:
  - Latch cfg_num_layers, all addresses, width and height.
  - Compute input_framesize = width*height as unsigned 24-bit; 4095*4095 fits.
  - Clear aborted, timeout_err, layer_idx.
  - Later cfg_* changes have no effect until the next start.
- States: IDLE, LAUNCH, RUN, NEXT, DONE, ERR.
  - IDLE/DONE/ERR + cfg_start:
    - num_layers==0 -> DONE, with seq_done pulsed the next cycle and no ap_start.
    - Otherwise -> LAUNCH; ap_start=1 in the cycle after cfg_start.
  - LAUNCH: ap_start=1, busy=1. On ap_ready (same cycle as ap_start) -> RUN; ap_start drops the next cycle. The watchdog counter is cleared on entry.
  - RUN: ap_start=0; the counter increments each cycle.
    - ap_done -> NEXT.
    - cfg_timeout!=0 and counter==cfg_timeout-1 without ap_done -> ERR; timeout_err=1, busy=0, seq_done pulse.
    - ap_done and timeout in the same cycle: ap_done wins.
  - NEXT (1 cycle):
    - If abort is pending or layer_idx==num_layers-1 -> DONE, with seq_done pulsed on entry. aborted=1 if ending early on abort.
    - Otherwise layer_idx++ -> LAUNCH.
    - Latency from ap_done to the next ap_start is exactly 2 cycles.
  - DONE/ERR: busy=0; wait for cfg_start.
- Abort:
  - cfg_abort in LAUNCH/RUN/NEXT sets abort_pend; the current layer always runs to ap_done.
  - abort_pend is cleared on DONE and ignored in IDLE/DONE/ERR.
  - Abort on the last layer still ends normally, with aborted=0.
- Address rules (registered, valid while ap_start=1 and stable through RUN):
  - read_address = cfg_in_addr when layer_idx==0; otherwise buf[(layer_idx-1)%2], where buf0=cfg_buf0_addr and buf1=cfg_buf1_addr.
  - write_address = cfg_out_addr when layer_idx==num_layers-1; otherwise buf[layer_idx%2].
  - A single layer reads in and writes out.
- Stray inputs:
  - ap_done outside RUN is ignored.
  - ap_ready outside LAUNCH is ignored.
  - ap_idle is informational only; it is not required for launch.

Test Plan:
- 3-layer run (in=0x1000, b0=0x2000, b1=0x3000, out=0x4000, 64x32), with ap_ready=1 and ap_done 10 cycles after start -> three ap_start pulses.
  - Addresses (rd,wr) = (0x1000,0x2000), (0x2000,0x3000), (0x3000,0x4000).
  - framesize = 2048; layer_idx 0,1,2; one seq_done; busy low after.
- ap_ready delayed 5 cycles -> ap_start held high exactly until the ap_ready cycle, then low; addresses stable throughout.
- cfg_timeout=20 and no ap_done -> timeout_err=1 twenty cycles after entering RUN, then seq_done pulse, state ERR. A new cfg_start clears timeout_err and relaunches.
- 4-layer run with cfg_abort during layer 1 -> layer 1 completes, no layer 2 start, aborted=1, seq_done once, last write_address=0x2000/0x3000 per ping-pong.
- cfg_num_layers=0 -> no ap_start, seq_done two cycles after cfg_start. Separately, cfg_start while busy is ignored.
- ARESET asserted mid-RUN -> all outputs 0 immediately; a late ap_done after reset release is ignored.

Source files
------------

// File: rtl/cnn_layer_scheduler.sv
// Multi-layer CNN sequencer: issues one ap_start per layer to the DMA/CNN core and
// ping-pongs intermediate feature maps between two DDR buffers, with watchdog and abort.
module cnn_layer_scheduler #(
    parameter int LAYER_W = 4,
    parameter int ADDR_W  = 32,
    parameter int TMO_W   = 32
) (
    input  logic               ap_clk,
    input  logic               ARESET,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [LAYER_W-1:0] cfg_num_layers,
    input  logic [ADDR_W-1:0]  cfg_in_addr,
    input  logic [ADDR_W-1:0]  cfg_out_addr,
    input  logic [ADDR_W-1:0]  cfg_buf0_addr,
    input  logic [ADDR_W-1:0]  cfg_buf1_addr,
    input  logic [11:0]        cfg_width,
    input  logic [11:0]        cfg_height,
    input  logic [TMO_W-1:0]   cfg_timeout,
    output logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_idle,
    output logic [ADDR_W-1:0]  read_address,
    output logic [ADDR_W-1:0]  write_address,
    output logic [11:0]        input_width,
    output logic [11:0]        input_height,
    output logic [23:0]        input_framesize,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               busy,
    output logic               seq_done,
    output logic               aborted,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [LAYER_W-1:0] IDX_ONE = LAYER_W'(1);
    localparam logic [TMO_W-1:0]   TMO_ONE = TMO_W'(1);

    // Layer 0 reads the input frame; layer k>0 reads what layer k-1 wrote.
    function automatic logic [ADDR_W-1:0] rd_addr_f(
        input logic [LAYER_W-1:0] idx,
        input logic [ADDR_W-1:0]  in_a,
        input logic [ADDR_W-1:0]  b0,
        input logic [ADDR_W-1:0]  b1
    );
        if (idx == '0) return in_a;
        return idx[0] ? b0 : b1;
    endfunction

    function automatic logic [ADDR_W-1:0] wr_addr_f(
        input logic [LAYER_W-1:0] idx,
        input logic [LAYER_W-1:0] num,
        input logic [ADDR_W-1:0]  out_a,
        input logic [ADDR_W-1:0]  b0,
        input logic [ADDR_W-1:0]  b1
    );
        if (idx == num - IDX_ONE) return out_a;
        return idx[0] ? b1 : b0;
    endfunction

    state_t             state_q;
    logic [LAYER_W-1:0] num_q;
    logic [ADDR_W-1:0]  out_q;
    logic [ADDR_W-1:0]  b0_q;
    logic [ADDR_W-1:0]  b1_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [TMO_W-1:0]   cnt_q;
    logic               abort_pend_q;
    logic               empty_pend_q;
    logic               ap_start_q;
    logic [ADDR_W-1:0]  rd_q;
    logic [ADDR_W-1:0]  wr_q;
    logic [11:0]        w_q;
    logic [11:0]        h_q;
    logic [23:0]        fs_q;
    logic [LAYER_W-1:0] idx_q;
    logic               busy_q;
    logic               seq_done_q;
    logic               aborted_q;
    logic               tmo_err_q;

    logic [LAYER_W-1:0] idx_d;
    logic [23:0]        fs_d;
    logic               last_layer_d;
    logic               abort_now_d;
    logic               tmo_hit_d;
    logic               unused_idle;

    assign idx_d        = idx_q + IDX_ONE;
    assign fs_d         = 24'(cfg_width) * 24'(cfg_height);
    assign last_layer_d = (idx_q == num_q - IDX_ONE);
    assign abort_now_d  = abort_pend_q | cfg_abort;
    assign tmo_hit_d    = (tmo_q != '0) && (cnt_q == tmo_q - TMO_ONE);
    assign unused_idle  = ap_idle;

    always_ff @(posedge ap_clk or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            out_q        <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
            tmo_q        <= '0;
            cnt_q        <= '0;
            abort_pend_q <= 1'b0;
            empty_pend_q <= 1'b0;
            ap_start_q   <= 1'b0;
            rd_q         <= '0;
            wr_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            fs_q         <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            seq_done_q   <= 1'b0;
            aborted_q    <= 1'b0;
            tmo_err_q    <= 1'b0;
        end else begin
            seq_done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    // An empty sequence reports completion one cycle after reaching DONE.
                    empty_pend_q <= 1'b0;
                    if (state_q == S_DONE && empty_pend_q) seq_done_q <= 1'b1;
                    if (cfg_start) begin
                        num_q        <= cfg_num_layers;
                        out_q        <= cfg_out_addr;
                        b0_q         <= cfg_buf0_addr;
                        b1_q         <= cfg_buf1_addr;
                        tmo_q        <= cfg_timeout;
                        w_q          <= cfg_width;
                        h_q          <= cfg_height;
                        fs_q         <= fs_d;
                        idx_q        <= '0;
                        aborted_q    <= 1'b0;
                        tmo_err_q    <= 1'b0;
                        abort_pend_q <= 1'b0;
                        if (cfg_num_layers == '0) begin
                            state_q      <= S_DONE;
                            empty_pend_q <= 1'b1;
                        end else begin
                            state_q    <= S_LAUNCH;
                            ap_start_q <= 1'b1;
                            busy_q     <= 1'b1;
                            cnt_q      <= '0;
                            rd_q       <= rd_addr_f('0, cfg_in_addr, cfg_buf0_addr, cfg_buf1_addr);
                            wr_q       <= wr_addr_f('0, cfg_num_layers, cfg_out_addr,
                                                    cfg_buf0_addr, cfg_buf1_addr);
                        end
                    end
                end
                S_LAUNCH: begin
                    if (cfg_abort) abort_pend_q <= 1'b1;
                    if (ap_ready) begin
                        ap_start_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cfg_abort) abort_pend_q <= 1'b1;
                    // Completion takes priority over a watchdog expiry in the same cycle.
                    if (ap_done) begin
                        state_q <= S_NEXT;
                    end else if (tmo_hit_d) begin
                        state_q      <= S_ERR;
                        tmo_err_q    <= 1'b1;
                        busy_q       <= 1'b0;
                        seq_done_q   <= 1'b1;
                        abort_pend_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + TMO_ONE;
                    end
                end
                S_NEXT: begin
                    if (abort_now_d || last_layer_d) begin
                        state_q      <= S_DONE;
                        busy_q       <= 1'b0;
                        seq_done_q   <= 1'b1;
                        aborted_q    <= abort_now_d && !last_layer_d;
                        abort_pend_q <= 1'b0;
                    end else begin
                        idx_q      <= idx_d;
                        rd_q       <= rd_addr_f(idx_d, b0_q, b0_q, b1_q);
                        wr_q       <= wr_addr_f(idx_d, num_q, out_q, b0_q, b1_q);
                        ap_start_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_LAUNCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ap_start        = ap_start_q;
    assign read_address    = rd_q;
    assign write_address   = wr_q;
    assign input_width     = w_q;
    assign input_height    = h_q;
    assign input_framesize = fs_q;
    assign layer_idx       = idx_q;
    assign busy            = busy_q;
    assign seq_done        = seq_done_q;
    assign aborted         = aborted_q;
    assign timeout_err     = tmo_err_q;

endmodule
